tagger_run_ctrl: RTL and testbench

- Run controller placed between the host command path and the event_tagger.
- Sequences one acquisition run: it zeroes the tagger timer, enables counting and capture for a programmed number of cycles or until STOP, then drains in-flight records and signals completion.
- Buffers tagger records in a 2-entry FIFO toward a valid/ready sink, and counts delivered and dropped records.

---
 rtl/tagger_pkg.sv | 27 ++
 rtl/rec_fifo2.sv | 63 ++++++
 rtl/tagger_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tagger_run_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tagger_pkg.sv
// Shared definitions for the tagger run controller: record layout, host
// command encodings and the run-sequencer state encoding.
package tagger_pkg;

    localparam int unsigned N_CHANNELS = 4;
    localparam int unsigned DATA_WIDTH = 43 + N_CHANNELS;

    // Record bit positions
    localparam int unsigned TS_LSB   = 0;
    localparam int unsigned TS_MSB   = 35;
    localparam int unsigned WRAP_BIT = 42 + N_CHANNELS;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_START = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } run_state_e;

endpackage

// File: rtl/rec_fifo2.sv
// Two-entry in-order FIFO with registered valid/full flags.
// Ports: clk, reset (async, active-high), push/push_data, pop,
//        head_data (oldest entry), valid (not empty), full.
module rec_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    always_comb begin
        do_pop    = pop && valid;
        do_push   = push && (!full || do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 2'd1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;
            valid <= (count_nxt != 2'd0);
            full  <= (count_nxt == 2'd2);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/tagger_run_ctrl.sv
// Acquisition run controller in front of the event_tagger. Sequences
// IDLE -> ARM -> RUN -> DRAIN -> IDLE, drives the tagger control lines,
// buffers tagger records in a 2-entry FIFO toward a valid/ready sink and
// counts delivered and dropped records.
// Ports: clk, reset (async, active-high); host command cmd_valid/cmd_op/
//        cmd_duration/cmd_ready; tagger controls tag_reset_counter,
//        tag_counter_operate, tag_capture_operate; tagger records
//        tag_data/tag_ready; sink rec_data/rec_valid/rec_ready; status
//        running, done, record_count, lost_count.
module tagger_run_ctrl #(
    parameter  int unsigned N_CHANNELS   = 4,
    parameter  int unsigned DUR_WIDTH    = 32,
    parameter  int unsigned DRAIN_CYCLES = 4,
    localparam int unsigned REC_WIDTH    = 43 + N_CHANNELS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    input  logic [DUR_WIDTH-1:0] cmd_duration,
    output logic                 cmd_ready,
    output logic                 tag_reset_counter,
    output logic                 tag_counter_operate,
    output logic                 tag_capture_operate,
    input  logic [REC_WIDTH-1:0] tag_data,
    input  logic                 tag_ready,
    output logic [REC_WIDTH-1:0] rec_data,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic                 running,
    output logic                 done,
    output logic [31:0]          record_count,
    output logic [15:0]          lost_count
);
    import tagger_pkg::*;

    localparam int unsigned     DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    run_state_e           state;
    run_state_e           state_nxt;
    logic [DUR_WIDTH-1:0] duration;
    logic [DUR_WIDTH-1:0] elapsed;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 start_idle;
    logic                 clear_counts;
    logic                 expire;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    // Record path: a same-cycle pop makes room on a full FIFO.
    assign pop  = rec_valid && rec_ready;
    assign push = tag_ready && (!fifo_full || pop);
    assign drop = tag_ready && !push;

    rec_fifo2 #(
        .WIDTH (REC_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (tag_data),
        .pop       (pop),
        .head_data (rec_data),
        .valid     (rec_valid),
        .full      (fifo_full)
    );

    // Next-state decode; STOP and expiry in the same cycle share one transition.
    always_comb begin
        state_nxt    = state;
        start_idle   = 1'b0;
        clear_counts = 1'b0;
        expire       = (duration != '0) && (elapsed == duration - DUR_WIDTH'(1));
        case (state)
            ST_IDLE: begin
                if (cmd_valid && (cmd_op == CMD_START)) begin
                    state_nxt    = ST_ARM;
                    start_idle   = 1'b1;
                    clear_counts = 1'b1;
                end else if (cmd_valid && (cmd_op == CMD_CLEAR)) begin
                    clear_counts = 1'b1;
                end
            end
            ST_ARM: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if ((cmd_valid && (cmd_op == CMD_STOP)) || expire) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((drain_cnt == DRAIN_LAST) && !rec_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus controls registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= ST_IDLE;
            tag_reset_counter   <= 1'b1;
            tag_counter_operate <= 1'b0;
            tag_capture_operate <= 1'b0;
            running             <= 1'b0;
            cmd_ready           <= 1'b1;
            done                <= 1'b0;
        end else begin
            state               <= state_nxt;
            tag_reset_counter   <= (state_nxt == ST_IDLE) || (state_nxt == ST_ARM);
            tag_counter_operate <= (state_nxt == ST_RUN);
            tag_capture_operate <= (state_nxt == ST_RUN);
            running             <= (state_nxt == ST_RUN);
            cmd_ready           <= (state_nxt == ST_IDLE) || (state_nxt == ST_RUN);
            done                <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
        end
    end

    // Run timing: latched duration, elapsed RUN cycles, DRAIN dwell counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duration  <= '0;
            elapsed   <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_idle) begin
                duration <= cmd_duration;
                elapsed  <= '0;
            end else if (state == ST_RUN) begin
                elapsed <= elapsed + DUR_WIDTH'(1);
            end
            if (state != ST_DRAIN) begin
                drain_cnt <= '0;
            end else if (drain_cnt != DRAIN_LAST) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
        end
    end

    // Delivered / dropped record counters; a clear wins over a same-cycle event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            record_count <= 32'd0;
            lost_count   <= 16'd0;
        end else if (clear_counts) begin
            record_count <= 32'd0;
            lost_count   <= 16'd0;
        end else begin
            if (push) begin
                record_count <= record_count + 32'd1;
            end
            if (drop && (lost_count != 16'hFFFF)) begin
                lost_count <= lost_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tagger_run_ctrl.sv
// Self-checking bench for tagger_run_ctrl: directed scenarios plus a
// randomized section, all compared every cycle against a behavioural model.
module tb_tagger_run_ctrl;
    import tagger_pkg::*;

    localparam int unsigned DUR_W   = 32;
    localparam int unsigned DRAIN_N = 4;
    localparam int unsigned DW      = DATA_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic [1:0]            cmd_op;
    logic [DUR_W-1:0]      cmd_duration;
    logic                  cmd_ready;
    logic                  tag_reset_counter;
    logic                  tag_counter_operate;
    logic                  tag_capture_operate;
    logic [DW-1:0]         tag_data;
    logic                  tag_ready;
    logic [DW-1:0]         rec_data;
    logic                  rec_valid;
    logic                  rec_ready;
    logic                  running;
    logic                  done;
    logic [31:0]           record_count;
    logic [15:0]           lost_count;

    tagger_run_ctrl #(
        .N_CHANNELS   (N_CHANNELS),
        .DUR_WIDTH    (DUR_W),
        .DRAIN_CYCLES (DRAIN_N)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_op              (cmd_op),
        .cmd_duration        (cmd_duration),
        .cmd_ready           (cmd_ready),
        .tag_reset_counter   (tag_reset_counter),
        .tag_counter_operate (tag_counter_operate),
        .tag_capture_operate (tag_capture_operate),
        .tag_data            (tag_data),
        .tag_ready           (tag_ready),
        .rec_data            (rec_data),
        .rec_valid           (rec_valid),
        .rec_ready           (rec_ready),
        .running             (running),
        .done                (done),
        .record_count        (record_count),
        .lost_count          (lost_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ARM, M_RUN, M_DRAIN} mphase_e;

    mphase_e       ph = M_IDLE;
    logic [DW-1:0] q[$];
    int            cyc = 0;
    longint        m_dur = 0;
    int            run_first = 0;
    int            drain_first = 0;
    longint        m_rec = 0;
    int            m_lost = 0;
    bit            m_done = 1'b0;

    // Stimulus / observation state
    logic [DW-1:0] dut_got[$];
    int            op_cycles = 0;
    int            done_pulses = 0;
    bit            wrap_pending = 1'b0;
    bit            op_prev = 1'b0;
    int            stub_t0 = 0;
    bit            strobe_req = 1'b0;
    logic [N_CHANNELS-1:0] strobe_mask = '0;

    function automatic logic [DW-1:0] make_rec(input int ts, input logic [N_CHANNELS-1:0] mask,
                                               input bit wrap);
        logic [DW-1:0] r;
        r = '0;
        r[TS_MSB:TS_LSB]    = 36'(ts);
        r[42 +: N_CHANNELS] = mask;
        r[WRAP_BIT]         = wrap;
        return r;
    endfunction

    // Apply one clock edge to the model using the inputs just sampled.
    task automatic model_edge();
        int      sz;
        bit      pop;
        bit      clr;
        mphase_e nph;
        sz  = q.size();
        cyc++;
        pop = (sz != 0) && rec_ready;
        if (pop) void'(q.pop_front());
        if (tag_ready) begin
            if (sz < 2 || pop) begin
                q.push_back(tag_data);
                m_rec = (m_rec + 1) & 64'hFFFF_FFFF;
            end else if (m_lost < 65535) begin
                m_lost++;
            end
        end
        clr = 1'b0;
        nph = ph;
        case (ph)
            M_IDLE: begin
                if (cmd_valid && cmd_op == CMD_START) begin
                    nph   = M_ARM;
                    m_dur = longint'(cmd_duration);
                    clr   = 1'b1;
                end else if (cmd_valid && cmd_op == CMD_CLEAR) begin
                    clr = 1'b1;
                end
            end
            M_ARM: begin
                nph       = M_RUN;
                run_first = cyc;
            end
            M_RUN: begin
                if ((cmd_valid && cmd_op == CMD_STOP) ||
                    (m_dur != 0 && longint'(cyc - 1 - run_first) == m_dur - 1)) begin
                    nph         = M_DRAIN;
                    drain_first = cyc;
                end
            end
            default: begin
                if ((cyc - 1 - drain_first) >= int'(DRAIN_N) - 1 && sz == 0) nph = M_IDLE;
            end
        endcase
        if (clr) begin
            m_rec  = 0;
            m_lost = 0;
        end
        m_done = (ph == M_DRAIN) && (nph == M_IDLE);
        ph     = nph;
    endtask

    task automatic check_outputs();
        chk("ctl_reset_counter", tag_reset_counter, ph == M_IDLE || ph == M_ARM);
        chk("ctl_counter_op", tag_counter_operate, ph == M_RUN);
        chk("ctl_capture_op", tag_capture_operate, ph == M_RUN);
        chk("running", running, ph == M_RUN);
        chk("cmd_ready", cmd_ready, ph == M_IDLE || ph == M_RUN);
        chk("done", done, m_done);
        chk("rec_valid", rec_valid, q.size() != 0);
        if (q.size() != 0) chk("rec_data", rec_data, q[0]);
        chk("record_count", record_count, m_rec);
        chk("lost_count", lost_count, m_lost);
    endtask

    // One clock: drive tagger stub, clock the model, check at the falling edge.
    task automatic cycle();
        if (wrap_pending) begin
            tag_ready = 1'b1;
            tag_data  = make_rec(0, '0, 1'b1);
        end else if (strobe_req) begin
            tag_ready = 1'b1;
            tag_data  = make_rec(cyc - stub_t0 + 1, strobe_mask, 1'b0);
        end else begin
            tag_ready = 1'b0;
            tag_data  = DW'({$urandom(), $urandom()});
        end
        if (rec_valid && rec_ready) dut_got.push_back(rec_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (tag_counter_operate) op_cycles++;
        if (done) done_pulses++;
        wrap_pending = tag_counter_operate && !op_prev;
        if (wrap_pending) stub_t0 = cyc;
        op_prev    = tag_counter_operate;
        cmd_valid  = 1'b0;
        strobe_req = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [DUR_W-1:0] dur);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_duration = dur;
        cycle();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            cycle();
            k++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    // Reset asserted mid-cycle; outputs must return to IDLE values at once.
    task automatic hit_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_rst_reset_counter"}, tag_reset_counter, 1'b1);
        chk({tag, "_rst_counter_op"}, tag_counter_operate, 1'b0);
        chk({tag, "_rst_capture_op"}, tag_capture_operate, 1'b0);
        chk({tag, "_rst_rec_valid"}, rec_valid, 1'b0);
        chk({tag, "_rst_rec_data"}, rec_data, '0);
        chk({tag, "_rst_record_count"}, record_count, 0);
        chk({tag, "_rst_lost_count"}, lost_count, 0);
        chk({tag, "_rst_done"}, done, 1'b0);
        chk({tag, "_rst_running"}, running, 1'b0);
        q.delete();
        ph           = M_IDLE;
        m_rec        = 0;
        m_lost       = 0;
        m_done       = 1'b0;
        wrap_pending = 1'b0;
        op_prev      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [DW-1:0] bp_first;

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = CMD_NOP;
        cmd_duration = '0;
        tag_ready    = 1'b0;
        tag_data     = '0;
        rec_ready    = 1'b1;
        @(negedge clk);
        hit_reset("init");
        repeat (2) cycle();

        // Timed run, no strobes: only the wrap marker is delivered.
        op_cycles = 0; done_pulses = 0; dut_got.delete();
        send(CMD_START, 10);
        wait_done("timed", 40);
        repeat (2) cycle();
        chk("timed_op_cycles", op_cycles, 10);
        chk("timed_done_pulses", done_pulses, 1);
        chk("timed_delivered", dut_got.size(), 1);
        if (dut_got.size() > 0) chk("timed_wrap_rec", dut_got[0], make_rec(0, '0, 1'b1));
        chk("timed_record_count", record_count, 1);
        chk("timed_back_idle", tag_reset_counter, 1'b1);

        // Backpressure: wrap + 1 strobe buffered, 2 strobes dropped.
        rec_ready = 1'b0; dut_got.delete(); done_pulses = 0;
        strobe_mask = N_CHANNELS'(1);
        send(CMD_START, 30);
        repeat (3) cycle();
        strobe_req = 1'b1; cycle(); bp_first = tag_data;
        cycle();
        strobe_req = 1'b1; cycle();
        cycle();
        strobe_req = 1'b1; cycle();
        send(CMD_STOP, 0);
        repeat (10) cycle();
        chk("bp_drain_held", done_pulses, 0);
        chk("bp_lost_count", lost_count, 2);
        chk("bp_record_count", record_count, 2);
        rec_ready = 1'b1;
        wait_done("bp", 20);
        chk("bp_delivered", dut_got.size(), 2);
        if (dut_got.size() == 2) begin
            chk("bp_order0", dut_got[0], make_rec(0, '0, 1'b1));
            chk("bp_order1", dut_got[1], bp_first);
        end

        // STOP in IDLE changes nothing; CLEAR zeroes the counters.
        cycle();
        send(CMD_STOP, 0);
        cycle();
        chk("idle_stop_records", record_count, 2);
        chk("idle_stop_lost", lost_count, 2);
        chk("idle_stop_running", running, 1'b0);
        chk("idle_stop_ready", cmd_ready, 1'b1);
        send(CMD_CLEAR, 0);
        chk("clear_records", record_count, 0);
        chk("clear_lost", lost_count, 0);

        // STOP coincident with expiry (duration 5).
        op_cycles = 0; done_pulses = 0;
        send(CMD_START, 5);
        for (int k = 0; k < 20 && op_cycles < 5; k++) cycle();
        send(CMD_STOP, 0);
        wait_done("coinc", 20);
        repeat (3) cycle();
        chk("coinc_op_cycles", op_cycles, 5);
        chk("coinc_done_pulses", done_pulses, 1);

        // Abort with 2 records buffered, then an unlimited run until STOP.
        rec_ready = 1'b0;
        send(CMD_START, 0);
        repeat (3) cycle();
        strobe_req = 1'b1; cycle();
        cycle();
        chk("abort_buffered", rec_valid, 1'b1);
        hit_reset("abort");
        op_cycles = 0;
        send(CMD_START, 0);
        for (int k = 0; k < 40; k++) begin
            rec_ready   = ($urandom_range(0, 3) != 0);
            strobe_req  = running && ($urandom_range(0, 2) == 0);
            strobe_mask = N_CHANNELS'($urandom_range(1, 15));
            cycle();
        end
        chk("unlim_running", running, 1'b1);
        chk("unlim_op_cycles", op_cycles, 40);
        rec_ready = 1'b1;
        send(CMD_STOP, 0);
        wait_done("unlim", 40);

        // START and CLEAR during RUN are ignored.
        op_cycles = 0;
        send(CMD_START, 12);
        repeat (4) cycle();
        send(CMD_START, 3);
        send(CMD_CLEAR, 0);
        wait_done("filter", 40);
        chk("filter_op_cycles", op_cycles, 12);
        chk("filter_record_count", record_count, 1);

        // Randomized commands, strobes and sink backpressure.
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i == 300) hit_reset("rnd");
            r           = int'($urandom_range(0, 99));
            rec_ready   = ($urandom_range(0, 9) < 7);
            strobe_req  = running && ($urandom_range(0, 2) == 0);
            strobe_mask = N_CHANNELS'($urandom_range(1, 15));
            if (r < 4) begin
                cmd_valid = 1'b1; cmd_op = CMD_START;
                cmd_duration = DUR_W'($urandom_range(1, 20));
            end else if (r < 6) begin
                cmd_valid = 1'b1; cmd_op = CMD_STOP;
            end else if (r < 8) begin
                cmd_valid = 1'b1; cmd_op = CMD_CLEAR;
            end else if (r < 10) begin
                cmd_valid = 1'b1; cmd_op = CMD_NOP;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
